varredura_matriz: RTL and testbench

- Downstream drive stage for the 5x7 LED matrix of the irrigation panel. It consumes a full 35-bit frame from the matrix-composition logic (time digits, watering type, water level) and time-multiplexes it onto the physical column and row lines.
- Double-buffered, so a new frame never tears mid-scan.
- Contains its own scan-rate prescaler and an anti-ghosting blanking interval at every column change.

---
 rtl/matriz_pkg.sv | 19 +
 rtl/varredura_matriz_divisor_tick.sv | 33 +++
 rtl/varredura_matriz.sv | 128 ++++++++++++
 tb/tb_varredura_matriz.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matriz_pkg.sv
// Shared types and helpers for the 5x7 LED matrix drive path.
// Frame layout: column c occupies bits [7c+6:7c]; bit 7c+r is row r of column c.
package matriz_pkg;

  localparam int NUM_COLUNAS    = 5;
  localparam int NUM_LINHAS     = 7;
  localparam int LARGURA_QUADRO = 35;

  typedef enum logic {BLANK, SHOW} estadoT;

  function automatic logic [NUM_LINHAS-1:0] fatia_coluna(
    input logic [LARGURA_QUADRO-1:0] quadro,
    input logic [2:0]                idx
  );
    if (int'(idx) >= NUM_COLUNAS) return '0;
    return quadro[int'(idx)*NUM_LINHAS +: NUM_LINHAS];
  endfunction

endpackage

// File: rtl/varredura_matriz_divisor_tick.sv
// Free-running prescaler: one-cycle tick every CLK_DIV enabled cycles.
// Held at zero while disabled so each enable restarts a full period.
module divisor_tick
  import matriz_pkg::*;
#(
  parameter int CLK_DIV = 5000
) (
  input  logic displayClock,
  input  logic resetN,
  input  logic habilitar,
  output logic tick
);

  localparam int            CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] ULTIMO = CW'(CLK_DIV - 1);

  logic [CW-1:0] contagem;

  always_ff @(posedge displayClock or negedge resetN) begin
    if (!resetN) begin
      contagem <= '0;
    end else if (!habilitar) begin
      contagem <= '0;
    end else if (contagem == ULTIMO) begin
      contagem <= '0;
    end else begin
      contagem <= contagem + 1'b1;
    end
  end

  assign tick = habilitar && (contagem == ULTIMO);

endmodule

// File: rtl/varredura_matriz.sv
// Double-buffered column scanner for the 5x7 panel matrix with a blanking
// interval at the start of every column slot; frames swap only at wrap to column 0.
module varredura_matriz
  import matriz_pkg::*;
#(
  parameter int CLK_DIV     = 5000,
  parameter int DWELL_TICKS = 4,
  parameter int BLANK_TICKS = 1
) (
  input  logic        displayClock,
  input  logic        resetN,
  input  logic        habilitar,
  input  logic [34:0] quadro,
  input  logic        quadroValido,
  output logic        quadroPronto,
  output logic [4:0]  colunas,
  output logic [6:0]  linhas,
  output logic [2:0]  colunaAtual,
  output logic        fimQuadro
);

  localparam int SW         = $clog2(DWELL_TICKS);
  localparam int BLANK_LAST = (BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0;

  logic tick;

  divisor_tick #(
    .CLK_DIV(CLK_DIV)
  ) uDivisor (
    .displayClock(displayClock),
    .resetN      (resetN),
    .habilitar   (habilitar),
    .tick        (tick)
  );

  estadoT                    estado, estadoNxt;
  logic [SW-1:0]             slot, slotNxt;
  logic [2:0]                colNxt;
  logic [LARGURA_QUADRO-1:0] ativo, ativoNxt;
  logic [LARGURA_QUADRO-1:0] sombra, sombraNxt;
  logic                      pendente, pendenteNxt;
  logic                      troca;
  logic                      mostrando;
  logic                      transferencia;

  assign transferencia = quadroValido && !pendente;
  // With no blanking the BLANK state left after reset/disable behaves as SHOW.
  assign mostrando     = (estado == SHOW) || (BLANK_TICKS == 0);

  always_comb begin
    estadoNxt   = estado;
    slotNxt     = slot;
    colNxt      = colunaAtual;
    ativoNxt    = ativo;
    sombraNxt   = sombra;
    pendenteNxt = pendente;
    troca       = 1'b0;

    if (transferencia) begin
      sombraNxt   = quadro;
      pendenteNxt = 1'b1;
    end

    if (!habilitar) begin
      estadoNxt = BLANK;
      slotNxt   = '0;
      colNxt    = '0;
    end else if (!mostrando) begin
      if (tick) begin
        if (slot == SW'(BLANK_LAST)) estadoNxt = SHOW;
        slotNxt = slot + 1'b1;
      end
    end else begin
      estadoNxt = SHOW;
      if (tick) begin
        if (slot == SW'(DWELL_TICKS - 1)) begin
          slotNxt   = '0;
          estadoNxt = (BLANK_TICKS == 0) ? SHOW : BLANK;
          if (colunaAtual == 3'(NUM_COLUNAS - 1)) begin
            colNxt = '0;
            // Frame boundary: a pending frame replaces the active one here only.
            if (pendente) begin
              ativoNxt    = sombra;
              pendenteNxt = 1'b0;
              troca       = 1'b1;
            end
          end else begin
            colNxt = colunaAtual + 3'd1;
          end
        end else begin
          slotNxt = slot + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge displayClock or negedge resetN) begin
    if (!resetN) begin
      estado       <= BLANK;
      slot         <= '0;
      colunaAtual  <= '0;
      ativo        <= '0;
      sombra       <= '0;
      pendente     <= 1'b0;
      quadroPronto <= 1'b1;
      fimQuadro    <= 1'b0;
      colunas      <= '0;
      linhas       <= 7'h7F;
    end else begin
      estado       <= estadoNxt;
      slot         <= slotNxt;
      colunaAtual  <= colNxt;
      ativo        <= ativoNxt;
      sombra       <= sombraNxt;
      pendente     <= pendenteNxt;
      quadroPronto <= ~pendenteNxt;
      fimQuadro    <= troca;
      if (estadoNxt == SHOW) begin
        colunas <= 5'b00001 << colNxt;
        linhas  <= ~fatia_coluna(ativoNxt, colNxt);
      end else begin
        colunas <= '0;
        linhas  <= 7'h7F;
      end
    end
  end

endmodule

// File: tb/tb_varredura_matriz.sv
// Self-checking bench: two scanner configurations compared every cycle against
// an arithmetic model of scan position plus a frame-buffer scoreboard.
module tb_varredura_matriz;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetN;
  logic        hab [2];
  logic        vld [2];
  logic [34:0] frm [2];

  logic [4:0] col0, col1;
  logic [6:0] lin0, lin1;
  logic [2:0] ca0, ca1;
  logic       qp0, qp1, fim0, fim1;

  int checks = 0;
  int errors = 0;

  int cdP [2] = '{4, 1};
  int dwP [2] = '{4, 2};
  int btP [2] = '{1, 0};

  int          n      [2] = '{0, 0};
  logic [34:0] pendF  [2] = '{35'd0, 35'd0};
  logic [34:0] disp   [2] = '{35'd0, 35'd0};
  bit          pendV  [2] = '{1'b0, 1'b0};
  bit          fimExp [2] = '{1'b0, 1'b0};
  bit          rdy1Prev = 1'b0;

  varredura_matriz #(.CLK_DIV(4), .DWELL_TICKS(4), .BLANK_TICKS(1)) dut0 (
    .displayClock(clk), .resetN(resetN), .habilitar(hab[0]),
    .quadro(frm[0]), .quadroValido(vld[0]), .quadroPronto(qp0),
    .colunas(col0), .linhas(lin0), .colunaAtual(ca0), .fimQuadro(fim0)
  );

  varredura_matriz #(.CLK_DIV(1), .DWELL_TICKS(2), .BLANK_TICKS(0)) dut1 (
    .displayClock(clk), .resetN(resetN), .habilitar(hab[1]),
    .quadro(frm[1]), .quadroValido(vld[1]), .quadroPronto(qp1),
    .colunas(col1), .linhas(lin1), .colunaAtual(ca1), .fimQuadro(fim1)
  );

  // Reference: n = enabled edges since restart; every CLK_DIV-th edge is a tick,
  // a frame is 5*DWELL ticks, and a pending frame takes over at each frame end.
  always @(posedge clk or negedge resetN) begin
    bit rdy;
    if (!resetN) begin
      for (int i = 0; i < 2; i++) begin
        n[i] = 0; pendV[i] = 1'b0; pendF[i] = '0; disp[i] = '0; fimExp[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        rdy       = !pendV[i];
        fimExp[i] = 1'b0;
        if (!hab[i]) begin
          n[i] = 0;
        end else begin
          n[i] = n[i] + 1;
          if ((n[i] % (cdP[i] * dwP[i] * 5)) == 0 && pendV[i]) begin
            disp[i]   = pendF[i];
            pendV[i]  = 1'b0;
            fimExp[i] = 1'b1;
          end
        end
        if (vld[i] && rdy) begin
          pendF[i] = frm[i];
          pendV[i] = 1'b1;
        end
      end
    end
  end

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkInst(input int i);
    int         c;
    bit         s;
    logic [4:0] eCol;
    logic [6:0] eLin;
    c    = (n[i] == 0) ? 0 : ((n[i] / cdP[i]) / dwP[i]) % 5;
    s    = (n[i] > 0) && (((n[i] / cdP[i]) % dwP[i]) >= btP[i]);
    eCol = s ? 5'(1 << c) : 5'd0;
    eLin = s ? ~disp[i][7*c +: 7] : 7'h7F;
    cmp($sformatf("i%0d_colunas", i), 64'(i == 0 ? col0 : col1), 64'(eCol));
    cmp($sformatf("i%0d_linhas", i), 64'(i == 0 ? lin0 : lin1), 64'(eLin));
    cmp($sformatf("i%0d_colunaAtual", i), 64'(i == 0 ? ca0 : ca1), 64'(c));
    cmp($sformatf("i%0d_fimQuadro", i), 64'(i == 0 ? fim0 : fim1), 64'(fimExp[i]));
    cmp($sformatf("i%0d_quadroPronto", i), 64'(i == 0 ? qp0 : qp1), 64'(!pendV[i]));
  endtask

  task automatic stepCheck(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      checkInst(0);
      checkInst(1);
      if (vld[1] && rdy1Prev) frm[1] = 35'({$urandom(), $urandom()});
      rdy1Prev = qp1;
    end
  endtask

  task automatic waitFim(input int inst, input int bound, output int cnt, output bit seen);
    cnt  = 0;
    seen = 1'b0;
    for (int c = 0; c < bound; c++) begin
      stepCheck(1);
      cnt++;
      if ((inst == 0) ? fim0 : fim1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic sendFrame(input logic [34:0] f, output int waited);
    bit prev;
    frm[0] = f;
    vld[0] = 1'b1;
    waited = 0;
    prev   = 1'b0;
    for (int c = 0; c < 400; c++) begin
      prev = qp0;
      stepCheck(1);
      waited++;
      if (prev) break;
    end
    vld[0] = 1'b0;
    cmp("send_accepted", 64'(prev), 64'd1);
  endtask

  initial begin
    int  cnt;
    int  waited;
    bit  seen;
    bit  found;
    bit  rdy0;

    resetN = 1'b0;
    hab[0] = 1'b0; hab[1] = 1'b0;
    vld[0] = 1'b0; vld[1] = 1'b0;
    frm[0] = '0;   frm[1] = '0;
    stepCheck(3);
    cmp("reset_colunas", 64'(col0), 64'd0);
    cmp("reset_linhas", 64'(lin0), 64'h7F);
    cmp("reset_pronto", 64'(qp0), 64'd1);

    resetN = 1'b1;
    hab[1] = 1'b1;
    vld[1] = 1'b1;
    frm[1] = 35'({$urandom(), $urandom()});
    stepCheck(2);

    // First frame after enable
    hab[0] = 1'b1;
    frm[0] = 35'h1_2345_6789;
    vld[0] = 1'b1;
    stepCheck(1);
    vld[0] = 1'b0;
    waitFim(0, 200, cnt, seen);
    cmp("fim_first_seen", 64'(seen), 64'd1);
    cmp("fim_first_latency", 64'(cnt + 1), 64'd80);
    stepCheck(4);
    cmp("col0_linhas", 64'(lin0), 64'h76);
    cmp("col0_colunas", 64'(col0), 64'h01);

    // Back-to-back frames: B must stall until A is swapped in
    sendFrame(35'({$urandom(), $urandom()}), waited);
    cmp("a_immediate", 64'(waited), 64'd1);
    sendFrame(35'({$urandom(), $urandom()}), waited);
    cmp("b_stalled", 64'(waited > 1), 64'd1);
    stepCheck(100);

    // Transfer in the exact boundary-tick cycle
    found = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!pendV[0] && ((n[0] + 1) % 80) == 0) begin
        found = 1'b1;
        break;
      end
      stepCheck(1);
    end
    cmp("boundary_align", 64'(found), 64'd1);
    frm[0] = 35'({$urandom(), $urandom()});
    vld[0] = 1'b1;
    stepCheck(1);
    vld[0] = 1'b0;
    cmp("no_fim_at_xfer", 64'(fim0), 64'd0);
    waitFim(0, 200, cnt, seen);
    cmp("boundary_xfer_seen", 64'(seen), 64'd1);
    cmp("boundary_xfer_latency", 64'(cnt), 64'd80);

    // Disable at column 3, accept a frame while disabled, then re-enable
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      stepCheck(1);
      if (ca0 == 3'd3 && col0 != 5'd0) begin
        found = 1'b1;
        break;
      end
    end
    cmp("reach_col3", 64'(found), 64'd1);
    hab[0] = 1'b0;
    stepCheck(1);
    cmp("dis_colunas", 64'(col0), 64'd0);
    cmp("dis_linhas", 64'(lin0), 64'h7F);
    cmp("dis_colunaAtual", 64'(ca0), 64'd0);
    sendFrame(35'({$urandom(), $urandom()}), waited);
    cmp("dis_pending", 64'(qp0), 64'd0);
    stepCheck(5);
    hab[0] = 1'b1;
    stepCheck(3);
    cmp("reen_blank", 64'(col0), 64'd0);
    stepCheck(1);
    cmp("reen_col0", 64'(col0), 64'd1);
    waitFim(0, 100, cnt, seen);
    cmp("reen_swap", 64'(cnt + 4), 64'd80);

    // Asynchronous reset during SHOW with a frame pending
    sendFrame(35'({$urandom(), $urandom()}), waited);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (col0 != 5'd0) begin
        found = 1'b1;
        break;
      end
      stepCheck(1);
    end
    cmp("pre_rst_show", 64'(found), 64'd1);
    cmp("pre_rst_pending", 64'(qp0), 64'd0);
    @(posedge clk);
    #2 resetN = 1'b0;
    #1;
    cmp("arst_colunas", 64'(col0), 64'd0);
    cmp("arst_linhas", 64'(lin0), 64'h7F);
    cmp("arst_pronto", 64'(qp0), 64'd1);
    cmp("arst_colunaAtual", 64'(ca0), 64'd0);
    stepCheck(1);
    resetN = 1'b1;
    stepCheck(6);
    cmp("post_rst_colunas", 64'(col0), 64'd1);
    cmp("post_rst_linhas", 64'(lin0), 64'h7F);

    // No-blank configuration: fimQuadro cadence
    waitFim(1, 40, cnt, seen);
    cmp("i1_fim_seen", 64'(seen), 64'd1);
    waitFim(1, 40, cnt, seen);
    cmp("i1_cadence", 64'(cnt), 64'd10);

    // Randomized traffic with occasional enable toggles
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 49) == 0) hab[0] = ~hab[0];
      rdy0 = qp0;
      stepCheck(1);
      if (!vld[0] || rdy0) begin
        vld[0] = 1'($urandom_range(0, 1));
        frm[0] = 35'({$urandom(), $urandom()});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
